// File: rtl/shift_seq.sv
// shift_seq: frames up to four bytes into a shift-register driver as
// strobed commands (master reset, shift byte, storage latch, output enable).
// Build option: define SHIFT_SEQ_MR_EN to prefix every frame with a
// master-reset (cmd 00) strobe; undefined, frames start directly with bytes.
// Ports:
//   clk, rst         clock, async active-high reset
//   start, nbyte,    frame request; nbyte = bytes-1, wdata = payload
//   wdata
//   oe_req, oe_val   output-enable update request and level (active low)
//   busy, finish     frame in progress / one-cycle completion pulse
//   sft_vld, sft_cmd command strobe and code to the driver
//   sft_din, sft_oen byte for cmd 01 / level for cmd 11
//   sft_done         driver completion pulse for cmd 01 and cmd 10
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  nbyte,
  input  logic [31:0] wdata,
  input  logic        oe_req,
  input  logic        oe_val,
  output logic        busy,
  output logic        finish,
  output logic        sft_vld,
  output logic [1:0]  sft_cmd,
  output logic [7:0]  sft_din,
  output logic        sft_oen,
  input  logic        sft_done
);

  typedef enum logic [2:0] {
    IDLE,
    MR,
    SHIFT,
    WAIT_SH,
    LATCH,
    WAIT_ST,
    FIN
  } state_t;

  localparam logic [1:0] CMD_MR = 2'b00;
  localparam logic [1:0] CMD_SH = 2'b01;
  localparam logic [1:0] CMD_ST = 2'b10;
  localparam logic [1:0] CMD_OE = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        fin_q, fin_d;
  logic        vld_q, vld_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [7:0]  din_q, din_d;
  logic        oen_q, oen_d;
  logic        pend_q, pend_d;
  logic        oev_q, oev_d;
  logic        issue_oe;
  logic [1:0]  idx_m1;

  function automatic logic [7:0] sel_byte(
    input logic [31:0] d,
    input logic [1:0]  i
  );
    sel_byte = d[{i, 3'b000} +: 8];
  endfunction

  assign idx_m1 = idx_q - 2'd1;

  // Outputs are registered: the strobe for a state is set up on the
  // edge that enters it, so it is visible during that state's cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    fin_d    = 1'b0;
    vld_d    = 1'b0;
    cmd_d    = cmd_q;
    din_d    = 8'h00;
    oen_d    = oen_q;
    pend_d   = pend_q;
    oev_d    = oev_q;
    issue_oe = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d = wdata;
          idx_d  = nbyte;
`ifdef SHIFT_SEQ_MR_EN
          state_d = MR;
          vld_d   = 1'b1;
          cmd_d   = CMD_MR;
`else
          state_d = SHIFT;
          vld_d   = 1'b1;
          cmd_d   = CMD_SH;
          din_d   = sel_byte(wdata, nbyte);
`endif
        end else if (pend_q) begin
          issue_oe = 1'b1;
        end
      end
`ifdef SHIFT_SEQ_MR_EN
      MR: begin
        state_d = SHIFT;
        vld_d   = 1'b1;
        cmd_d   = CMD_SH;
        din_d   = sel_byte(data_q, idx_q);
      end
`endif
      SHIFT: state_d = WAIT_SH;
      WAIT_SH: begin
        if (sft_done) begin
          if (idx_q != 2'd0) begin
            idx_d   = idx_m1;
            state_d = SHIFT;
            vld_d   = 1'b1;
            cmd_d   = CMD_SH;
            din_d   = sel_byte(data_q, idx_m1);
          end else begin
            state_d = LATCH;
            vld_d   = 1'b1;
            cmd_d   = CMD_ST;
          end
        end
      end
      LATCH: state_d = WAIT_ST;
      WAIT_ST: begin
        if (sft_done) begin
          state_d = FIN;
          fin_d   = 1'b1;
        end
      end
      // Leaving FIN lets a deferred OE land in the first IDLE cycle.
      FIN: begin
        state_d  = IDLE;
        issue_oe = pend_q;
      end
      default: state_d = IDLE;
    endcase
    if (issue_oe) begin
      vld_d  = 1'b1;
      cmd_d  = CMD_OE;
      oen_d  = oev_q;
      pend_d = 1'b0;
    end
    // A request in the issue cycle re-arms with the new level.
    if (oe_req) begin
      pend_d = 1'b1;
      oev_d  = oe_val;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      data_q  <= 32'h0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      vld_q   <= 1'b0;
      cmd_q   <= CMD_MR;
      din_q   <= 8'h00;
      oen_q   <= 1'b1;
      pend_q  <= 1'b0;
      oev_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      vld_q   <= vld_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      oen_q   <= oen_d;
      pend_q  <= pend_d;
      oev_q   <= oev_d;
    end
  end

  assign busy    = busy_q;
  assign finish  = fin_q;
  assign sft_vld = vld_q;
  assign sft_cmd = cmd_q;
  assign sft_din = din_q;
  assign sft_oen = oen_q;

endmodule
